// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: ALU op encodings and
// default datapath geometry.
package id_ex_stage_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int RADDR_DEF = 5;
  localparam int CNTW_DEF  = 16;
  localparam int REG_ZERO  = 0;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_SLT   = 3'd4,
    ALU_MUL   = 3'd5,
    ALU_DIV   = 3'd6,
    ALU_PASSB = 3'd7
  } alu_op_e;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Single-operand bypass select: EX/MEM beats MEM/WB beats stored data;
// register zero is never bypassed.
module fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int RADDR = RADDR_DEF
) (
  input  logic [RADDR-1:0] addr,
  input  logic [WIDTH-1:0] data,
  input  logic             exm_reg_write,
  input  logic [RADDR-1:0] exm_rd,
  input  logic [WIDTH-1:0] exm_result,
  input  logic             wb_reg_write,
  input  logic [RADDR-1:0] wb_rd,
  input  logic [WIDTH-1:0] wb_result,
  output logic [WIDTH-1:0] fwd
);

  logic nz;
  assign nz = (addr != RADDR'(REG_ZERO));

  always_comb begin
    fwd = data;
    if (nz && exm_reg_write && (exm_rd == addr))
      fwd = exm_result;
    else if (nz && wb_reg_write && (wb_rd == addr))
      fwd = wb_result;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, stall/flush handling
// and a saturating stall-cycle counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int RADDR = RADDR_DEF,
  parameter int CNTW  = CNTW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [RADDR-1:0] id_rs_addr,
  input  logic [RADDR-1:0] id_rt_addr,
  input  logic [RADDR-1:0] id_rd_addr,
  input  logic [WIDTH-1:0] id_rs_data,
  input  logic [WIDTH-1:0] id_rt_data,
  input  logic [WIDTH-1:0] id_imm,
  input  logic             id_use_imm,
  input  logic [2:0]       id_alu_sel,
  input  logic             id_reg_write,
  input  logic             flush,
  input  logic             ex_ready,
  input  logic             exm_reg_write,
  input  logic [RADDR-1:0] exm_rd,
  input  logic [WIDTH-1:0] exm_result,
  input  logic             wb_reg_write,
  input  logic [RADDR-1:0] wb_rd,
  input  logic [WIDTH-1:0] wb_result,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [2:0]       SEL,
  output logic             ex_valid,
  output logic [RADDR-1:0] ex_rd,
  output logic             ex_reg_write,
  output logic [CNTW-1:0]  stall_cnt
);

  logic             valid_q, we_q, use_imm_q;
  alu_op_e          sel_q;
  logic [RADDR-1:0] rs_addr_q, rt_addr_q, rd_q;
  logic [WIDTH-1:0] rs_data_q, rt_data_q, imm_q;
  logic [CNTW-1:0]  stall_cnt_q;

  logic [1:0][RADDR-1:0] src_addr;
  logic [1:0][WIDTH-1:0] src_data, src_fwd;

  assign src_addr = {rt_addr_q, rs_addr_q};
  assign src_data = {rt_data_q, rs_data_q};

  // Index 0 = rs, 1 = rt; outputs also feed the stall refresh.
  for (genvar g = 0; g < 2; g++) begin : g_fwd
    fwd_mux #(.WIDTH(WIDTH), .RADDR(RADDR)) u_fwd (
      .addr          (src_addr[g]),
      .data          (src_data[g]),
      .exm_reg_write (exm_reg_write),
      .exm_rd        (exm_rd),
      .exm_result    (exm_result),
      .wb_reg_write  (wb_reg_write),
      .wb_rd         (wb_rd),
      .wb_result     (wb_result),
      .fwd           (src_fwd[g])
    );
  end

  logic xfer, handoff, stall;
  assign id_ready = !valid_q || ex_ready;
  assign xfer     = id_valid && id_ready;
  assign handoff  = valid_q && ex_ready;
  assign stall    = valid_q && !ex_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      we_q        <= 1'b0;
      use_imm_q   <= 1'b0;
      sel_q       <= ALU_ADD;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      rd_q        <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      stall_cnt_q <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
    end else if (xfer) begin
      valid_q   <= 1'b1;
      we_q      <= id_reg_write;
      use_imm_q <= id_use_imm;
      sel_q     <= alu_op_e'(id_alu_sel);
      rs_addr_q <= id_rs_addr;
      rt_addr_q <= id_rt_addr;
      rd_q      <= id_rd_addr;
      rs_data_q <= id_rs_data;
      rt_data_q <= id_rt_data;
      imm_q     <= id_imm;
    end else if (handoff) begin
      valid_q <= 1'b0;
    end else if (stall) begin
      // Latch bypassed values so a producer retiring mid-stall is not lost.
      rs_data_q <= src_fwd[0];
      rt_data_q <= src_fwd[1];
      if (stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign A            = src_fwd[0];
  assign B            = use_imm_q ? imm_q : src_fwd[1];
  assign SEL          = sel_q;
  assign ex_valid     = valid_q;
  assign ex_rd        = rd_q;
  assign ex_reg_write = we_q && valid_q;
  assign stall_cnt    = stall_cnt_q;

endmodule
